// File: rtl/ticket_kiosk_arbiter_if.sv
// rtl/ticket_kiosk_arbiter_if.sv - kiosk request/response bundle for the ticket arbiter
interface ticket_kiosk_arbiter_if #(
    parameter int NUM_KIOSKS = 4
);
    logic [NUM_KIOSKS-1:0]   req;
    logic [2*NUM_KIOSKS-1:0] req_cat;
    logic [NUM_KIOSKS-1:0]   ack;
    logic                    resp_ok;
    logic [2:0]              resp_kiosk;

    modport master (
        output req, req_cat,
        input  ack, resp_ok, resp_kiosk
    );

    modport slave (
        input  req, req_cat,
        output ack, resp_ok, resp_kiosk
    );
endinterface

// File: rtl/ticket_kiosk_arbiter.sv
// rtl/ticket_kiosk_arbiter.sv - round-robin kiosk arbiter owning the shared ticket inventory
// Optional restock port set enabled by defining TICKET_RESTOCK_EN.
module ticket_kiosk_arbiter #(
    parameter int NUM_KIOSKS = 4,
    parameter int CNT_W      = 8,
    parameter int VIP_INIT   = 8,
    parameter int REG_INIT   = 12,
    parameter int STU_INIT   = 5,
    parameter int SEN_INIT   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ticket_kiosk_arbiter_if.slave bus,
`ifdef TICKET_RESTOCK_EN
    input  logic                 restock_valid,
    input  logic [1:0]           restock_cat,
    input  logic [CNT_W-1:0]     restock_qty,
`endif
    output logic                 busy,
    output logic [CNT_W-1:0]     available_vip,
    output logic [CNT_W-1:0]     available_regular,
    output logic [CNT_W-1:0]     available_student,
    output logic [CNT_W-1:0]     available_senior,
    output logic [3:0]           sold_out
);
    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             rr_ptr_q, rr_ptr_d;
    logic [2:0]             win_q, win_d;
    logic [1:0]             cat_q, cat_d;
    logic                   res_ok_q, res_ok_d;
    logic [NUM_KIOSKS-1:0]  ack_q, ack_d;
    logic                   resp_ok_q, resp_ok_d;
    logic [2:0]             resp_kiosk_q, resp_kiosk_d;
    logic                   busy_q, busy_d;
    logic [3:0]             sold_out_q, sold_out_d;
    logic [CNT_W-1:0]       cnt_q [4];
    logic [CNT_W-1:0]       cnt_d [4];

    logic [7:0]             req_ext;
    logic [3:0]             sum;
    logic                   found;
    logic [2:0]             pick;
    logic [1:0]             cat_pick;
`ifdef TICKET_RESTOCK_EN
    logic [CNT_W:0]         sat_sum;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        cat_d        = cat_q;
        res_ok_d     = res_ok_q;
        ack_d        = '0;
        resp_ok_d    = 1'b0;
        resp_kiosk_d = resp_kiosk_q;
        for (int c = 0; c < 4; c++) cnt_d[c] = cnt_q[c];

        // The kiosk acked last cycle still shows req until it reacts; keep it out of the scan.
        req_ext  = 8'(bus.req & ~ack_q);
        found    = 1'b0;
        pick     = '0;
        sum      = '0;
        cat_pick = '0;
        for (int i = 0; i < NUM_KIOSKS; i++) begin
            sum = {1'b0, rr_ptr_q} + 4'(i);
            if (sum >= 4'(NUM_KIOSKS)) sum = sum - 4'(NUM_KIOSKS);
            if (!found && req_ext[sum[2:0]]) begin
                found = 1'b1;
                pick  = sum[2:0];
            end
        end
        for (int k = 0; k < NUM_KIOSKS; k++) begin
            if (3'(k) == pick) cat_pick = bus.req_cat[2*k +: 2];
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    cat_d   = cat_pick;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cnt_q[cat_q] != '0) begin
                    cnt_d[cat_q] = cnt_q[cat_q] - CNT_W'(1);
                    res_ok_d     = 1'b1;
                end else begin
                    res_ok_d     = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                ack_d        = {{(NUM_KIOSKS-1){1'b0}}, 1'b1} << win_q;
                resp_ok_d    = res_ok_q;
                resp_kiosk_d = win_q;
                rr_ptr_d     = (win_q == 3'(NUM_KIOSKS - 1)) ? 3'd0 : win_q + 3'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef TICKET_RESTOCK_EN
        // Applied on top of any purchase decrement so both land in the same edge.
        if (restock_valid) begin
            sat_sum = {1'b0, cnt_d[restock_cat]} + {1'b0, restock_qty};
            cnt_d[restock_cat] = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
        end else begin
            sat_sum = '0;
        end
`endif

        busy_d = (state_d != IDLE) || (ack_d != '0);
        for (int c = 0; c < 4; c++) sold_out_d[c] = (cnt_d[c] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            cat_q        <= '0;
            res_ok_q     <= 1'b0;
            ack_q        <= '0;
            resp_ok_q    <= 1'b0;
            resp_kiosk_q <= '0;
            busy_q       <= 1'b0;
            cnt_q[0]     <= CNT_W'(VIP_INIT);
            cnt_q[1]     <= CNT_W'(REG_INIT);
            cnt_q[2]     <= CNT_W'(STU_INIT);
            cnt_q[3]     <= CNT_W'(SEN_INIT);
            sold_out_q   <= {SEN_INIT == 0, STU_INIT == 0, REG_INIT == 0, VIP_INIT == 0};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            cat_q        <= cat_d;
            res_ok_q     <= res_ok_d;
            ack_q        <= ack_d;
            resp_ok_q    <= resp_ok_d;
            resp_kiosk_q <= resp_kiosk_d;
            busy_q       <= busy_d;
            for (int c = 0; c < 4; c++) cnt_q[c] <= cnt_d[c];
            sold_out_q   <= sold_out_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.resp_ok       = resp_ok_q;
    assign bus.resp_kiosk    = resp_kiosk_q;
    assign busy              = busy_q;
    assign available_vip     = cnt_q[0];
    assign available_regular = cnt_q[1];
    assign available_student = cnt_q[2];
    assign available_senior  = cnt_q[3];
    assign sold_out          = sold_out_q;
endmodule
